ll_fifo_scheduler: RTL and testbench
====================================

# ll_fifo_scheduler

Round-robin push/pop scheduler for the shared `linked_list_fifo`, which holds NUM_FIFOS virtual FIFOs in one DEPTH-entry pool. It takes per-FIFO producer valid/ready streams and per-FIFO consumer ready signals and issues at most one push and one pop per cycle to the shared FIFO. It enforces a per-FIFO occupancy quota so one requester cannot starve the others of pool entries. It sits directly in front of `linked_list_fifo`, which is the sole consumer of its push/pop outputs.

## Interface
- WIDTH, 4, data width
- DEPTH, 4, shared pool entries (power of two, ≥2)
- NUM_FIFOS, 2, virtual FIFOs (≥2)
- QUOTA, DEPTH-1, max entries one FIFO may occupy (1..DEPTH)
- SEL_WIDTH, $clog2(NUM_FIFOS), select width
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- in_valid  in  NUM_FIFOS  producer i has data
- in_data  in  NUM_FIFOS*WIDTH  producer i data, slice [i*WIDTH +: WIDTH]
- in_ready  out  NUM_FIFOS  one-hot or zero; push grant to producer i
- out_ready  in  NUM_FIFOS  consumer i accepts data
- out_valid  out  NUM_FIFOS  registered, one-hot or zero; data for consumer i
- out_data  out  WIDTH  registered popped data
- ll_push, ll_pop  out  1  to linked_list_fifo
- ll_push_sel, ll_pop_sel  out  SEL_WIDTH  to linked_list_fifo
- ll_data_in  out  WIDTH  to linked_list_fifo
- ll_full  in  1  from linked_list_fifo
- ll_empty  in  NUM_FIFOS  from linked_list_fifo
- ll_data_out  in  WIDTH  head of ll_pop_sel, valid in the ll_pop cycle

## Operation
- State: count[i] (SEL… width $clog2(DEPTH)+1), total (same width), push_rr and pop_rr pointers (SEL_WIDTH), out_valid/out_data registers.
- Push eligibility i: in_valid[i] & count[i] < QUOTA & total < DEPTH & ~ll_full. Eligibility uses registered counts only, so an entry freed by a pop in the same cycle is not reusable until the next cycle.
- Pop eligibility i: count[i] != 0 & ~ll_empty[i] & out_ready[i].
- Arbitration: independent round-robin for push and pop. Search starts at the rr pointer and wraps modulo NUM_FIFOS. The first eligible index wins. On a grant, the pointer is set to winner+1 (mod NUM_FIFOS). With no grant, the pointer holds.
- Push grant w: ll_push=1, ll_push_sel=w, ll_data_in=in_data[w], in_ready[w]=1. All of these are combinational in the grant cycle.
- Pop grant p: ll_pop=1, ll_pop_sel=p. On the next edge, out_data<=ll_data_out and out_valid<=one-hot(p). Otherwise out_valid<=0.
- Counters: count[i] <= count[i] + push_i - pop_i; total <= total + ll_push - ll_pop. The same FIFO may be pushed and popped in one cycle when count≥1; its count is then unchanged.
- Idle defaults: ll_push_sel, ll_pop_sel, and ll_data_in drive 0 when not granted.
- Invariants (checked by assertions): count[i] ≤ QUOTA; sum count = total ≤ DEPTH; ll_push → ~ll_full; ll_pop → ~ll_empty[ll_pop_sel]; (count[i]==0) == ll_empty[i].

## Timing
- Reset (rst=1 at edge): counts=0, total=0, push_rr=pop_rr=0, out_valid=0, out_data=0. Combinational outputs are 0 during reset, and no grants are issued while rst is high.
- Reset mid-stream discards all in-flight state. linked_list_fifo shares rst and resets in the same cycle.
- Push latency: the data is in the pool at the edge ending the grant cycle. It is poppable the following cycle.
- Pop latency: out_valid asserts 1 cycle after ll_pop. The earliest push-to-out_valid latency is 2 cycles.
- Sustained throughput: 1 push and 1 pop per cycle.

## Test plan
- Reset then idle: all outputs 0. Single push on FIFO0 with data 0xA -> in_ready[0]=1 that cycle; with out_ready[0]=1, ll_pop the next cycle, and out_valid=01 with out_data=0xA the cycle after.
- Fairness: in_valid=11 continuously with DEPTH=4, QUOTA=3, and no pops -> grants alternate 0,1,0,1. After 4 pushes total=4, and in_ready=00 thereafter.
- Quota: only FIFO1 valid with QUOTA=3 -> 3 pushes granted, the 4th is held. A pop from FIFO1 re-enables the push one cycle later, not in the same cycle.
- Full boundary with simultaneous pop: total=4, and in one cycle a pop of FIFO0 plus in_valid[1] -> no push that cycle, push granted next cycle, total returns to 4.
- Same-FIFO push+pop at count[0]=1 -> both grants issue, count[0] stays 1, FIFO order preserved (data 3 then 5 emerges 3,5).
- Mid-stream reset with total=3 -> next cycle all counts 0, out_valid=0, rr pointers 0, and the first post-reset grant goes to FIFO0.

Source files
------------

// File: rtl/ll_fifo_scheduler.sv
// ll_fifo_scheduler
//
// Round-robin push/pop scheduler in front of linked_list_fifo. NUM_FIFOS
// virtual FIFOs share one DEPTH-entry pool. Each cycle at most one producer
// is granted a push and at most one consumer a pop. A per-FIFO occupancy
// quota keeps a single requester from taking every pool entry.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   in_valid      per-producer data-available flags
//   in_data       producer data, producer i in slice [i*WIDTH +: WIDTH]
//   in_ready      one-hot (or zero) push grant, combinational
//   out_ready     per-consumer accept flags
//   out_valid     one-hot (or zero), registered, one cycle after ll_pop
//   out_data      registered popped data (holds between pops)
//   ll_push/ll_push_sel/ll_data_in   push command to linked_list_fifo
//   ll_pop/ll_pop_sel                pop command to linked_list_fifo
//   ll_full, ll_empty, ll_data_out   status and head data from linked_list_fifo
module ll_fifo_scheduler #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int NUM_FIFOS = 2,
  parameter int QUOTA     = DEPTH - 1,
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_FIFOS-1:0]       in_valid,
  input  logic [NUM_FIFOS*WIDTH-1:0] in_data,
  output logic [NUM_FIFOS-1:0]       in_ready,
  input  logic [NUM_FIFOS-1:0]       out_ready,
  output logic [NUM_FIFOS-1:0]       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       ll_push,
  output logic                       ll_pop,
  output logic [SEL_WIDTH-1:0]       ll_push_sel,
  output logic [SEL_WIDTH-1:0]       ll_pop_sel,
  output logic [WIDTH-1:0]           ll_data_in,
  input  logic                       ll_full,
  input  logic [NUM_FIFOS-1:0]       ll_empty,
  input  logic [WIDTH-1:0]           ll_data_out
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] QUOTA_C = CW'(QUOTA);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]        count [NUM_FIFOS];
  logic [CW-1:0]        total;
  logic [SEL_WIDTH-1:0] push_rr;
  logic [SEL_WIDTH-1:0] pop_rr;
  logic [NUM_FIFOS-1:0] push_elig;
  logic [NUM_FIFOS-1:0] pop_elig;
  logic [NUM_FIFOS-1:0] push_oh;
  logic [NUM_FIFOS-1:0] pop_oh;

  // First requester at or after ptr, wrapping modulo NUM_FIFOS.
  function automatic logic [NUM_FIFOS-1:0] rr_pick(input logic [NUM_FIFOS-1:0] req,
                                                   input logic [SEL_WIDTH-1:0] ptr);
    int   idx;
    logic found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_FIFOS) idx = idx - NUM_FIFOS;
      if (!found && req[idx]) begin
        rr_pick[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  endfunction

  function automatic logic [SEL_WIDTH-1:0] oh_to_sel(input logic [NUM_FIFOS-1:0] oh);
    oh_to_sel = '0;
    for (int i = 0; i < NUM_FIFOS; i++)
      if (oh[i]) oh_to_sel = SEL_WIDTH'(i);
  endfunction

  // Pointer moves to winner+1 on a grant and holds otherwise.
  function automatic logic [SEL_WIDTH-1:0] next_ptr(input logic [NUM_FIFOS-1:0] oh,
                                                    input logic [SEL_WIDTH-1:0] ptr);
    next_ptr = ptr;
    for (int i = 0; i < NUM_FIFOS; i++)
      if (oh[i]) next_ptr = (i == NUM_FIFOS - 1) ? '0 : SEL_WIDTH'(i + 1);
  endfunction

  // Eligibility looks only at registered counts: an entry freed by a pop this
  // cycle becomes usable for a push on the next cycle, never the same one.
  always_comb begin
    for (int i = 0; i < NUM_FIFOS; i++) begin
      push_elig[i] = ~rst & in_valid[i] & (count[i] < QUOTA_C) & (total < DEPTH_C) & ~ll_full;
      pop_elig[i]  = ~rst & (count[i] != '0) & ~ll_empty[i] & out_ready[i];
    end
  end

  assign push_oh     = rr_pick(push_elig, push_rr);
  assign pop_oh      = rr_pick(pop_elig, pop_rr);
  assign in_ready    = push_oh;
  assign ll_push     = |push_oh;
  assign ll_pop      = |pop_oh;
  assign ll_push_sel = oh_to_sel(push_oh);
  assign ll_pop_sel  = oh_to_sel(pop_oh);

  always_comb begin
    // NOTE: assign a default before any conditional write so no latch is inferred.
    ll_data_in = '0;
    for (int i = 0; i < NUM_FIFOS; i++)
      if (push_oh[i]) ll_data_in = in_data[i*WIDTH +: WIDTH];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the count array is control state, not data storage, so every
      // element is reset; the pool contents live in linked_list_fifo.
      for (int i = 0; i < NUM_FIFOS; i++) count[i] <= '0;
      total     <= '0;
      push_rr   <= '0;
      pop_rr    <= '0;
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      // A same-FIFO push and pop cancel, leaving that count unchanged.
      for (int i = 0; i < NUM_FIFOS; i++)
        count[i] <= count[i] + CW'(push_oh[i]) - CW'(pop_oh[i]);
      total     <= total + CW'(ll_push) - CW'(ll_pop);
      push_rr   <= next_ptr(push_oh, push_rr);
      pop_rr    <= next_ptr(pop_oh, pop_rr);
      out_valid <= pop_oh;
      if (ll_pop) out_data <= ll_data_out;
    end
  end

`ifndef SYNTHESIS
  int cnt_sum;

  always_comb begin
    cnt_sum = 0;
    for (int i = 0; i < NUM_FIFOS; i++) cnt_sum = cnt_sum + int'(count[i]);
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FIFOS; i++) begin
        assert (count[i] <= QUOTA_C);
        assert ((count[i] == '0) == ll_empty[i]);
      end
      assert (cnt_sum == int'(total));
      assert (total <= DEPTH_C);
      if (ll_push) assert (!ll_full);
      if (ll_pop)  assert (!ll_empty[ll_pop_sel]);
    end
  end
`endif

endmodule

// File: tb/tb_ll_fifo_scheduler.sv
// Testbench for ll_fifo_scheduler. Contains a behavioural stand-in for
// linked_list_fifo (per-FIFO circular buffers), a queue-based model of the
// scheduling rules compared against the DUT every cycle, and directed
// sequences with hand-computed literal expectations.
module tb_ll_fifo_scheduler;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int NF    = 2;
  localparam int QUOTA = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    in_valid;
  logic [7:0]    in_data;
  logic [1:0]    in_ready;
  logic [1:0]    out_ready;
  logic [1:0]    out_valid;
  logic [3:0]    out_data;
  logic          ll_push, ll_pop;
  logic          ll_push_sel, ll_pop_sel;
  logic [3:0]    ll_data_in;
  logic          ll_full;
  logic [1:0]    ll_empty;
  logic [3:0]    ll_data_out;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  ll_fifo_scheduler #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_FIFOS(NF), .QUOTA(QUOTA), .SEL_WIDTH(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .ll_push(ll_push), .ll_pop(ll_pop),
    .ll_push_sel(ll_push_sel), .ll_pop_sel(ll_pop_sel),
    .ll_data_in(ll_data_in), .ll_full(ll_full), .ll_empty(ll_empty),
    .ll_data_out(ll_data_out)
  );

  // Stand-in for linked_list_fifo: follows whatever the DUT commands.
  logic [3:0] env_mem [2][4];
  int         env_cnt [2];
  int         env_head[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        env_cnt[i]  <= 0;
        env_head[i] <= 0;
      end
    end else begin
      if (ll_push)
        env_mem[ll_push_sel][(env_head[ll_push_sel] + env_cnt[ll_push_sel]) % 4] <= ll_data_in;
      if (ll_pop)
        env_head[ll_pop_sel] <= (env_head[ll_pop_sel] + 1) % 4;
      for (int i = 0; i < 2; i++)
        env_cnt[i] <= env_cnt[i] + ((ll_push && int'(ll_push_sel) == i) ? 1 : 0)
                                 - ((ll_pop  && int'(ll_pop_sel)  == i) ? 1 : 0);
    end
  end

  always_comb begin
    ll_full     = (env_cnt[0] + env_cnt[1]) == DEPTH;
    ll_empty[0] = env_cnt[0] == 0;
    ll_empty[1] = env_cnt[1] == 0;
    ll_data_out = env_mem[ll_pop_sel][env_head[ll_pop_sel]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each virtual FIFO is a queue; counts are queue sizes.
  logic [3:0] sb0[$];
  logic [3:0] sb1[$];

  initial begin : model
    int         m_prr, m_orr, m_total, idx;
    int         cnt[2];
    logic [1:0] m_ov, e_ready, e_pop;
    logic [3:0] m_od, e_pd;
    int         e_psel, e_osel;
    m_prr = 0; m_orr = 0; m_ov = '0; m_od = '0;
    forever begin
      @(negedge clk);
      cnt[0]  = sb0.size();
      cnt[1]  = sb1.size();
      m_total = cnt[0] + cnt[1];
      e_ready = '0; e_pop = '0; e_psel = 0; e_osel = 0; e_pd = '0;
      if (!rst) begin
        for (int k = 0; k < 2; k++) begin
          idx = (m_prr + k) % 2;
          if (e_ready == 2'b00 && in_valid[idx] && cnt[idx] < QUOTA && m_total < DEPTH) begin
            e_ready[idx] = 1'b1;
            e_psel       = idx;
            e_pd         = in_data[idx*4 +: 4];
          end
        end
        for (int k = 0; k < 2; k++) begin
          idx = (m_orr + k) % 2;
          if (e_pop == 2'b00 && cnt[idx] != 0 && out_ready[idx]) begin
            e_pop[idx] = 1'b1;
            e_osel     = idx;
          end
        end
      end
      check("m_in_ready",    32'(in_ready),    32'(e_ready));
      check("m_ll_push",     32'(ll_push),     32'(e_ready != 2'b00));
      check("m_ll_push_sel", 32'(ll_push_sel), 32'(e_psel));
      check("m_ll_data_in",  32'(ll_data_in),  32'(e_pd));
      check("m_ll_pop",      32'(ll_pop),      32'(e_pop != 2'b00));
      check("m_ll_pop_sel",  32'(ll_pop_sel),  32'(e_osel));
      check("m_out_valid",   32'(out_valid),   32'(m_ov));
      check("m_out_data",    32'(out_data),    32'(m_od));
      if (rst) begin
        sb0.delete(); sb1.delete();
        m_prr = 0; m_orr = 0; m_ov = '0; m_od = '0;
      end else begin
        if (e_pop != 2'b00) begin
          if (e_osel == 0) m_od = sb0.pop_front();
          else             m_od = sb1.pop_front();
          m_ov  = e_pop;
          m_orr = (e_osel + 1) % 2;
        end else begin
          m_ov = '0;
        end
        if (e_ready != 2'b00) begin
          if (e_psel == 0) sb0.push_back(e_pd);
          else             sb1.push_back(e_pd);
          m_prr = (e_psel + 1) % 2;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge clk);
    check("rst_no_push", 32'(ll_push), 32'd0);
    check("rst_no_pop",  32'(ll_pop),  32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = '0;
    tick();
    @(negedge clk);
    check("reset_in_ready",  32'(in_ready),  32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data",  32'(out_data),  32'd0);
    check("reset_data_in",   32'(ll_data_in), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_push", 32'(ll_push), 32'd0);
    check("idle_pop",  32'(ll_pop),  32'd0);
    tick();

    // Single push on FIFO0, popped next cycle, visible the cycle after.
    in_valid = 2'b01; in_data = 8'h0A; out_ready = 2'b01;
    @(negedge clk);
    check("t1_in_ready", 32'(in_ready), 32'h1);
    check("t1_data_in",  32'(ll_data_in), 32'hA);
    check("t1_no_pop",   32'(ll_pop), 32'd0);
    tick();
    in_valid = 2'b00;
    @(negedge clk);
    check("t1_pop",      32'(ll_pop), 32'd1);
    check("t1_pop_sel",  32'(ll_pop_sel), 32'd0);
    check("t1_ov_early", 32'(out_valid), 32'd0);
    tick();
    out_ready = 2'b00;
    @(negedge clk);
    check("t1_out_valid", 32'(out_valid), 32'h1);
    check("t1_out_data",  32'(out_data), 32'hA);
    tick();

    // Fairness: both valid, no pops -> 0,1,0,1 then blocked at total=4.
    in_valid = 2'b11; in_data = 8'h21;
    reset_pulse();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_grant", 32'(in_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("t2_data",  32'(ll_data_in), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t2_full_block", 32'(in_ready), 32'h0);
      tick();
    end

    // Full with a simultaneous pop: push held until the next cycle.
    in_valid = 2'b10; out_ready = 2'b01;
    @(negedge clk);
    check("t4_no_push", 32'(in_ready), 32'h0);
    check("t4_pop",     32'(ll_pop), 32'd1);
    check("t4_pop_sel", 32'(ll_pop_sel), 32'd0);
    tick();
    out_ready = 2'b00;
    @(negedge clk);
    check("t4_push_next", 32'(in_ready), 32'h2);
    check("t4_out_valid", 32'(out_valid), 32'h1);
    check("t4_out_data",  32'(out_data), 32'h1);
    tick();
    in_valid = 2'b01;
    @(negedge clk);
    check("t4_full_again", 32'(in_ready), 32'h0);
    tick();
    in_valid = 2'b00;
    reset_pulse();

    // Quota: FIFO1 alone gets three pushes; a pop frees it a cycle later.
    in_valid = 2'b10; in_data = 8'h70;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_grant", 32'(in_ready), 32'h2);
      tick();
    end
    @(negedge clk);
    check("t3_quota_hold", 32'(in_ready), 32'h0);
    tick();
    out_ready = 2'b10;
    @(negedge clk);
    check("t3_same_cycle", 32'(in_ready), 32'h0);
    check("t3_pop",        32'(ll_pop), 32'd1);
    check("t3_pop_sel",    32'(ll_pop_sel), 32'd1);
    tick();
    out_ready = 2'b00;
    @(negedge clk);
    check("t3_reenabled", 32'(in_ready), 32'h2);
    check("t3_out_valid", 32'(out_valid), 32'h2);
    check("t3_out_data",  32'(out_data), 32'h7);
    tick();
    in_valid = 2'b00;
    reset_pulse();

    // Same-FIFO push and pop at count=1 keeps order 3 then 5.
    in_valid = 2'b01; in_data = 8'h03;
    @(negedge clk);
    check("t5_push3", 32'(in_ready), 32'h1);
    tick();
    in_data = 8'h05; out_ready = 2'b01;
    @(negedge clk);
    check("t5_push5",    32'(in_ready), 32'h1);
    check("t5_data5",    32'(ll_data_in), 32'h5);
    check("t5_pop_both", 32'(ll_pop), 32'd1);
    tick();
    in_valid = 2'b00;
    @(negedge clk);
    check("t5_first_ov",  32'(out_valid), 32'h1);
    check("t5_first_dat", 32'(out_data), 32'h3);
    check("t5_pop_again", 32'(ll_pop), 32'd1);
    tick();
    out_ready = 2'b00;
    @(negedge clk);
    check("t5_second_dat", 32'(out_data), 32'h5);
    check("t5_drained",    32'(ll_pop), 32'd0);
    tick();

    // Mid-stream reset with three entries and a non-zero push pointer.
    in_valid = 2'b11; in_data = 8'h21;
    @(negedge clk);
    check("t6_g1", 32'(in_ready), 32'h2);
    tick();
    @(negedge clk);
    check("t6_g2", 32'(in_ready), 32'h1);
    tick();
    in_valid = 2'b01;
    @(negedge clk);
    check("t6_g3", 32'(in_ready), 32'h1);
    tick();
    in_valid = 2'b11;
    reset_pulse();
    out_ready = 2'b11;
    @(negedge clk);
    check("t6_first_grant", 32'(in_ready), 32'h1);
    check("t6_no_pop",      32'(ll_pop), 32'd0);
    check("t6_out_valid",   32'(out_valid), 32'h0);
    tick();
    @(negedge clk);
    check("t6_pop_sel", 32'(ll_pop_sel), 32'd0);
    check("t6_grant2",  32'(in_ready), 32'h2);
    tick();

    // Mixed traffic, checked by the model only, then drain.
    for (int i = 0; i < 48; i++) begin
      in_valid  = 2'((i * 5 + 1) % 4);
      out_ready = 2'((i * 7 + 2) % 4);
      in_data   = 8'(i * 17 + 3);
      tick();
    end
    in_valid = 2'b00; out_ready = 2'b11;
    repeat (8) tick();
    @(negedge clk);
    check("drain_empty", 32'(ll_empty), 32'h3);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
